cp0: RTL and testbench
======================

# cp0

Coprocessor 0 for the P7 pipeline: the consumer of the exception code produced in the M stage. Holds SR, Cause, EPC and PRId. Combines the M-stage exception code with the six external hardware interrupt lines to raise a single request `Req` that redirects fetch to the handler. Serves `mtc0`, `mfc0` and `eret` issued from the M stage.

## Interface
- `PRID`, default 32'h0000_2023: constant value returned by the PRId register (address 15).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  `mtc0` write enable (M stage).
- `CP0Addr`  in  5  register number for read and write.
- `CP0In`  in  32  `mtc0` write data.
- `CP0Out`  out  32  `mfc0` read data (combinational).
- `VPC`  in  32  PC of the M-stage instruction (the victim).
- `BDIn`  in  1  victim is in a branch delay slot.
- `ExcCodeIn`  in  5  M-stage exception code; 0 means none.
- `HWInt`  in  6  external interrupts; bit 2 is the interrupt generator, bits 1:0 are Timer1/Timer0.
- `EXLClr`  in  1  `eret` in M stage; clears EXL.
- `EPCOut`  out  32  current EPC register, for `eret`.
- `Req`  out  1  take exception/interrupt this cycle (combinational).

## Operation
- **SR (12):**
  - Only IM = SR[15:10], EXL = SR[1] and IE = SR[0] are stored.
  - All other bits read 0, and writes to them are discarded.
- **Cause (13):**
  - BD = [31], IP = [15:10], ExcCode = [6:2]; other bits read 0.
  - Read-only to `mtc0`; writes to address 13 are ignored.
  - IP is loaded from `HWInt` on every clock edge, unconditionally (reset excepted).
- **EPC (14):** full 32 bits, writable by `mtc0`.
- **PRId (15):** reads `PRID`; writes are ignored.
- **Other addresses:** read 32'h0; writes are ignored.
- **Request logic:**
  - IntReq = (|(HWInt & IM)) & IE & ~EXL.
  - ExcReq = (ExcCodeIn != 0) & ~EXL.
  - Req = IntReq | ExcReq.
- **On a clock edge with Req=1:**
  - EXL ← 1.
  - Cause.ExcCode ← IntReq ? 5'd0 : ExcCodeIn. Interrupt has priority over a simultaneous exception.
  - Cause.BD ← BDIn.
  - EPC ← BDIn ? VPC−4 : VPC, with bits [1:0] forced to 00. For an AdEL on an unaligned PC, the EPC is the aligned-down value.
  - Any `mtc0` in the same cycle is discarded; the faulting instruction does not commit.
- **Else if `en`=1:** write `CP0In` to the addressed register per the rules above.
- **`EXLClr`=1 with Req=0:** EXL ← 0.
  - EXLClr and an `mtc0` to SR in the same cycle: EXLClr wins for the EXL bit only; IM and IE take `CP0In`.
- **Address arithmetic:** VPC−4 is modulo 2^32.
- **Reset:** SR = 0, Cause = 0, EPC = 0.
  - After reset, `CP0Out` and `EPCOut` read 0; `CP0Out` reads `PRID` when `CP0Addr`=15.
  - `Req` = 0 after reset: EXL = 0 but IE = 0, and no exception code is present.

## Timing
- `Req` is combinational from `ExcCodeIn`, `HWInt` and the current SR, in the same cycle.
  - The pipeline flushes and loads PC 32'h0000_4180 on the edge that ends that cycle.
- Register effects of Req, `mtc0` and `EXLClr` are visible from the cycle after the edge.
- `CP0Out` and `EPCOut` return pre-edge register values; there is no internal write-to-read bypass.
- A second request while EXL=1 is masked: `Req` stays 0, including exceptions (ExcCodeIn≠0 with EXL=1 gives Req=0).
- IP lags `HWInt` by one cycle. `Req` uses live `HWInt`, not IP.
- `reset` asserted mid-operation (EXL=1, pending interrupt) clears all state at that edge; `Req` is 0 in the following cycle.

## Test plan
- **Reset/readback:**
  - Assert reset.
  - Read addresses 12, 13, 14, 15, 3 → 0, 0, 0, `PRID`, 0.
- **`mtc0` masking:**
  - Write 32'hFFFF_FFFF to SR → SR reads 32'h0000_FC03.
  - Write to Cause → unchanged.
  - Write 32'h0000_3010 to EPC → EPC reads 32'h0000_3010.
- **Exception capture:**
  - Setup: SR=0, VPC=32'h0000_3008, BDIn=1, ExcCodeIn=12.
  - Req=1 that cycle.
  - Next cycle: EPC=32'h0000_3004, Cause=32'h8000_0030, SR.EXL=1.
  - Further ExcCodeIn=4 → Req=0.
- **Interrupt vs exception priority:**
  - Setup: SR=32'h0000_0401, HWInt=6'b000001, ExcCodeIn=10, VPC=32'h0000_3001.
  - Req=1.
  - Next cycle: Cause.ExcCode=0, Cause.IP bit 10 set, EPC=32'h0000_3000.
- **`eret` and masking:**
  - EXLClr=1 → EXL=0 next cycle.
  - HWInt=6'b000100 with IM=6'b000011 → Req=0.
  - Set IM bit 12 → Req=1 the cycle after the write.
- **Simultaneous `mtc0` and Req:**
  - `en`=1 writing EPC=32'h0000_5000 while ExcCodeIn=5 and VPC=32'h0000_3100.
  - → EPC=32'h0000_3100; the `mtc0` write is discarded.

Source files
------------

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId storage plus exception/interrupt request generation.
// Latency: Req and CP0Out are combinational; register updates land on the next clk edge.
// Backpressure: none, single-cycle M-stage interface; Req flushes the pipeline externally.
module cp0 #(
    parameter logic [31:0] PRID = 32'h0000_2023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim_pc;

    // Requests use live HWInt rather than the lagging IP copy.
    assign int_req   = (|(HWInt & im)) & ie & ~exl;
    assign exc_req   = (ExcCodeIn != 5'd0) & ~exl;
    assign Req       = int_req | exc_req;
    assign victim_pc = BDIn ? (VPC - 32'd4) : VPC;
    assign EPCOut    = epc;

    logic unused_bits;
    assign unused_bits = ^{CP0In[31:16], CP0In[9:2], victim_pc[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                // The faulting instruction does not commit, so any mtc0 alongside is dropped.
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                bd       <= BDIn;
                epc      <= {victim_pc[31:2], 2'b00};
            end else begin
                if (en && CP0Addr == ADDR_SR) begin
                    im  <= CP0In[15:10];
                    exl <= CP0In[1];
                    ie  <= CP0In[0];
                end
                if (en && CP0Addr == ADDR_EPC) begin
                    epc <= CP0In;
                end
                // eret overrides only the EXL bit of a concurrent SR write.
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Addr)
            ADDR_SR:    CP0Out = {16'd0, im, 8'd0, exl, ie};
            ADDR_CAUSE: CP0Out = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
            ADDR_EPC:   CP0Out = epc;
            ADDR_PRID:  CP0Out = PRID;
            default:    CP0Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: directed vector table, a mid-operation reset sequence, and
// randomized traffic checked against a word-level model of the registers.
module tb_cp0;

    localparam logic [31:0] PRID_VAL = 32'h0000_2023;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    cp0 #(.PRID(PRID_VAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Addr   (CP0Addr),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        req;
        logic [31:0] out;
        logic [31:0] epc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model state: whole architectural words with the unimplemented bits held at 0.
    logic [31:0] m_sr    = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic [31:0] m_epc   = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic en_i, input logic [4:0] addr,
                                input logic [31:0] din, input logic [31:0] vpc, input logic bd,
                                input logic [4:0] exc, input logic [5:0] hw, input logic clr,
                                input logic req, input logic [31:0] out, input logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.en = en_i; v.addr = addr; v.din = din; v.vpc = vpc; v.bd = bd;
        v.exc = exc; v.hw = hw; v.clr = clr; v.req = req; v.out = out; v.epc = epc;
        return v;
    endfunction

    function automatic logic m_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] nsr, ncause, nepc, pc;
        if (reset) begin
            m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
            return;
        end
        nsr = m_sr; ncause = m_cause; nepc = m_epc;
        ncause[15:10] = HWInt;
        if (m_req()) begin
            nsr[1] = 1'b1;
            ncause[6:2] = m_int() ? 5'd0 : ExcCodeIn;
            ncause[31] = BDIn;
            pc = BDIn ? VPC - 32'd4 : VPC;
            nepc = pc & 32'hFFFF_FFFC;
        end else begin
            if (en && CP0Addr == 5'd12) nsr = CP0In & 32'h0000_FC03;
            if (en && CP0Addr == 5'd14) nepc = CP0In;
            if (EXLClr) nsr[1] = 1'b0;
        end
        m_sr = nsr; m_cause = ncause; m_epc = nepc;
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; en = v.en; CP0Addr = v.addr; CP0In = v.din; VPC = v.vpc;
        BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t tab[$];

    initial begin
        vec_t v;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();

        //            rst en addr  din            vpc            bd exc  hw      clr req out            epc
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0,         32'h0));
        tab.push_back(mk(0, 0, 13, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0,         32'h0));
        tab.push_back(mk(0, 0, 14, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0,         32'h0));
        tab.push_back(mk(0, 0, 15, 0,             0,             0, 0,  6'd0,   0, 0, PRID_VAL,      32'h0));
        tab.push_back(mk(0, 0, 3,  0,             0,             0, 0,  6'd0,   0, 0, 32'h0,         32'h0));
        tab.push_back(mk(0, 1, 12, 32'hFFFF_FFFF, 0,             0, 0,  6'd0,   0, 0, 32'h0,         32'h0));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_FC03, 32'h0));
        tab.push_back(mk(0, 1, 13, 32'hFFFF_FFFF, 0,             0, 0,  6'd0,   0, 0, 32'h0,         32'h0));
        tab.push_back(mk(0, 0, 13, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0,         32'h0));
        tab.push_back(mk(0, 1, 14, 32'h0000_3010, 0,             0, 0,  6'd0,   0, 0, 32'h0,         32'h0));
        tab.push_back(mk(0, 0, 14, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_3010, 32'h0000_3010));
        tab.push_back(mk(0, 1, 12, 32'h0,         0,             0, 0,  6'd0,   0, 0, 32'h0000_FC03, 32'h0000_3010));
        tab.push_back(mk(0, 0, 13, 0,             32'h0000_3008, 1, 12, 6'd0,   0, 1, 32'h0,         32'h0000_3010));
        tab.push_back(mk(0, 0, 14, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_3004, 32'h0000_3004));
        tab.push_back(mk(0, 0, 13, 0,             0,             0, 0,  6'd0,   0, 0, 32'h8000_0030, 32'h0000_3004));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_0002, 32'h0000_3004));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 4,  6'd0,   0, 0, 32'h0000_0002, 32'h0000_3004));
        tab.push_back(mk(0, 1, 12, 32'h0000_0401, 0,             0, 0,  6'd0,   0, 0, 32'h0000_0002, 32'h0000_3004));
        tab.push_back(mk(0, 0, 12, 0,             32'h0000_3001, 0, 10, 6'd1,   0, 1, 32'h0000_0401, 32'h0000_3004));
        tab.push_back(mk(0, 0, 13, 0,             0,             0, 0,  6'd1,   0, 0, 32'h0000_0400, 32'h0000_3000));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_0403, 32'h0000_3000));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd0,   1, 0, 32'h0000_0403, 32'h0000_3000));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_0401, 32'h0000_3000));
        tab.push_back(mk(0, 1, 12, 32'h0000_0C01, 0,             0, 0,  6'd0,   0, 0, 32'h0000_0401, 32'h0000_3000));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd4,   0, 0, 32'h0000_0C01, 32'h0000_3000));
        tab.push_back(mk(0, 1, 12, 32'h0000_1C01, 0,             0, 0,  6'd4,   0, 0, 32'h0000_0C01, 32'h0000_3000));
        tab.push_back(mk(0, 0, 13, 0,             32'h0000_3200, 0, 0,  6'd4,   0, 1, 32'h0000_1000, 32'h0000_3000));
        tab.push_back(mk(0, 0, 14, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_3200, 32'h0000_3200));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd0,   1, 0, 32'h0000_1C03, 32'h0000_3200));
        tab.push_back(mk(0, 1, 14, 32'h0000_5000, 32'h0000_3100, 0, 5,  6'd0,   0, 1, 32'h0000_3200, 32'h0000_3200));
        tab.push_back(mk(0, 0, 14, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_3100, 32'h0000_3100));
        tab.push_back(mk(0, 0, 13, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_0014, 32'h0000_3100));
        tab.push_back(mk(0, 1, 12, 32'h0000_0403, 0,             0, 0,  6'd0,   1, 0, 32'h0000_1C03, 32'h0000_3100));
        tab.push_back(mk(0, 0, 12, 0,             0,             0, 0,  6'd0,   0, 0, 32'h0000_0401, 32'h0000_3100));
        tab.push_back(mk(0, 0, 14, 0,             32'h0000_0000, 1, 8,  6'd0,   0, 1, 32'h0000_3100, 32'h0000_3100));
        tab.push_back(mk(0, 0, 14, 0,             0,             0, 0,  6'd0,   0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        tab.push_back(mk(0, 0, 13, 0,             0,             0, 0,  6'd0,   0, 0, 32'h8000_0020, 32'hFFFF_FFFC));
        tab.push_back(mk(0, 1, 15, 32'h0,         0,             0, 0,  6'd0,   0, 0, PRID_VAL,      32'hFFFF_FFFC));
        tab.push_back(mk(0, 0, 15, 0,             0,             0, 0,  6'd0,   0, 0, PRID_VAL,      32'hFFFF_FFFC));

        foreach (tab[i]) begin
            drive(tab[i]);
            @(negedge clk);
            chk($sformatf("row%0d req", i), {31'd0, Req}, {31'd0, tab[i].req});
            chk($sformatf("row%0d cp0out", i), CP0Out, tab[i].out);
            chk($sformatf("row%0d epcout", i), EPCOut, tab[i].epc);
            tick();
        end

        // Reset while EXL=1 with an interrupt line high clears everything at that edge.
        drive(mk(1, 0, 12, 0, 0, 0, 0, 6'd1, 0, 0, 0, 0));
        @(negedge clk);
        chk("midrst pre req", {31'd0, Req}, 32'd0);
        chk("midrst pre sr", CP0Out, 32'h0000_0403);
        tick();
        drive(mk(0, 0, 12, 0, 0, 0, 0, 6'd1, 0, 0, 0, 0));
        @(negedge clk);
        chk("midrst post req", {31'd0, Req}, 32'd0);
        chk("midrst post sr", CP0Out, 32'd0);
        chk("midrst post epc", EPCOut, 32'd0);
        tick();
        drive(mk(0, 0, 13, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0));
        @(negedge clk);
        chk("midrst ip lag", CP0Out, 32'h0000_0400);
        tick();

        for (int n = 0; n < 600; n++) begin
            int sel;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst  = ($urandom_range(0, 59) == 0);
            v.en   = ($urandom_range(0, 2) == 0);
            sel    = $urandom_range(0, 7);
            v.addr = (sel < 4) ? 5'(12 + sel) : 5'($urandom_range(0, 31));
            v.din  = $urandom();
            v.vpc  = $urandom();
            v.bd   = 1'($urandom_range(0, 1));
            v.exc  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            v.hw   = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            v.clr  = ($urandom_range(0, 5) == 0);
            drive(v);
            @(negedge clk);
            chk($sformatf("rnd%0d req", n), {31'd0, Req}, {31'd0, m_req()});
            chk($sformatf("rnd%0d cp0out a=%0d", n, CP0Addr), CP0Out, m_read(CP0Addr));
            chk($sformatf("rnd%0d epcout", n), EPCOut, m_epc);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
